hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard/bypass controller for the src0/src1 operand muxes. Runs in ID.
//  Shadows dst reg addr + write enable through the ID_EX, EX_DM and DM_WB stages.
//  Registers the byp0/1_EX and byp0/1_DM selects that the operand muxes consume
//  in EX.
//  Detects load-use hazards. Applies bubbles for taken-branch flushes.
//  Drives the per-stage stall signals.
// PARAMETERS
//  ADDR_W  4   register-file address width; R0 is hardwired zero
//  CNT_W   16  width of perf counters (only used with HAZ_PERF_CNT_EN)
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       async active-low reset
//  p0_addr        in   ADDR_W  ID src0 register address
//  p1_addr        in   ADDR_W  ID src1 register address
//  re0, re1       in   1       ID instr really reads p0/p1 (immediate forms =0)
//  dst_addr_ID    in   ADDR_W  ID destination address
//  we_ID          in   1       ID instr writes RF
//  ld_ID          in   1       ID instr is a DM load
//  flush          in   1       taken branch/jump resolved in EX; kill IF_ID + ID_EX
//  ext_stall      in   1       memory wait; freeze whole pipe
//  byp0_EX, byp1_EX  out  1    registered: select dst_EX_DM for src0/src1 in EX
//  byp0_DM, byp1_DM  out  1    registered: select dst_DM_WB for src0/src1 in EX
//  stall_IF_ID    out  1       hold PC and IF_ID flops
//  stall_ID_EX    out  1       hold ID_EX flops
//  stall_EX_DM    out  1       hold EX_DM flops
//  stall_DM_WB    out  1       hold DM_WB flops
//  bubble_ID_EX   out  1       load NOP (we/mem ctrl=0) into ID_EX
//  flush_IF_ID    out  1       load NOP into IF_ID
//  luse_cnt       out  CNT_W   load-use stall cycles (0 if feature off)
//  flush_cnt      out  CNT_W   flush cycles (0 if feature off)
// BEHAVIOUR
//  Reset: all trackers cleared.
//   - dst_* = 0, we_* = 0, ld_ID_EX = 0.
//   - All byp outputs = 0; all stall/bubble/flush outputs = 0; counters = 0.
//  Trackers: {dst,we} ID->ID_EX->EX_DM->DM_WB. ld tracked ID->ID_EX only.
//  Hazard match (ID): mX_EX = reX & weID_EX & (pX_addr == dstID_EX) & (pX_addr != 0).
//   mX_DM is the same test against EX_DM.
//  Load-use: luse = ld_ID_EX & (m0_EX | m1_EX).
//  Priority: ext_stall > flush > luse > normal.
//  ext_stall:
//   - All four stall outputs = 1; bubble/flush outputs = 0.
//   - All trackers and byp regs hold.
//  flush:
//   - flush_IF_ID = 1 and bubble_ID_EX = 1; stall outputs = 0.
//   - ID_EX tracker loads we = 0, ld = 0; byp regs load 0.
//  luse:
//   - stall_IF_ID = 1, bubble_ID_EX = 1; other stalls 0.
//   - ID_EX tracker loads we = 0; byp regs load 0. Exactly one bubble cycle.
//   - Next cycle the load is in EX_DM, so the retry gets bypX_DM = 1, bypX_EX = 0.
//  normal: all stall/bubble outputs 0.
//   - bypX_EX <= mX_EX & ~ld_ID_EX.
//   - bypX_DM <= mX_DM & ~mX_EX (EX distance wins; never both 1).
//  Stall/bubble/flush outputs are combinational from current ID inputs and tracker state.
//  byp outputs are flops, 1-cycle latency, aligned with the ID_EX operand flops.
//  Distance-3 producer (in WB) is handled by RF write-before-read; no bypass.
//  rst_n low mid-stall aborts the stall; first post-reset cycle is normal.
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined:
//   - luse_cnt +1 per cycle luse wins priority; flush_cnt +1 per flush cycle.
//   - Both saturate at all-ones; neither counts while ext_stall = 1.
//  HAZ_PERF_CNT_EN undefined: no counter flops; luse_cnt = flush_cnt = 0.
// TESTING
//  Reset: rst_n=0 with ext_stall=1 -> all outputs 0; after release byp*=0.
//  ADD R3 then ADD R5,R3,R4 -> next cycle byp0_EX=1, byp0_DM=0, no stall.
//   One NOP between -> byp0_DM=1.
//  LW R2 then SUB R6,R4,R2 -> one cycle stall_IF_ID=1, bubble_ID_EX=1.
//   Then byp1_DM=1, byp1_EX=0; luse_cnt=1 (feature on).
//  R0 dst or re0=0 with addr match (e.g. LLB) -> no bypass, no stall.
//  ext_stall=1 for 3 cycles during load-use -> all stalls 1, byp held.
//   After drop, exactly one bubble cycle follows.
//  flush=1 coincident with luse -> flush_IF_ID=1, bubble=1, stall_IF_ID=0;
//   flush_cnt=1, luse_cnt unchanged.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/bypass controller: shadows dst/we through the pipe, registers operand bypass selects,
// and drives stall/bubble/flush. Define HAZ_PERF_CNT_EN to build the load-use/flush counters.
module hazard_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              re0,
  input  logic              re1,
  input  logic [ADDR_W-1:0] dst_addr_ID,
  input  logic              we_ID,
  input  logic              ld_ID,
  input  logic              flush,
  input  logic              ext_stall,
  output logic              byp0_EX,
  output logic              byp1_EX,
  output logic              byp0_DM,
  output logic              byp1_DM,
  output logic              stall_IF_ID,
  output logic              stall_ID_EX,
  output logic              stall_EX_DM,
  output logic              stall_DM_WB,
  output logic              bubble_ID_EX,
  output logic              flush_IF_ID,
  output logic [CNT_W-1:0]  luse_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic [ADDR_W-1:0] dst_id_ex_q, dst_ex_dm_q, dst_dm_wb_q;
  logic              we_id_ex_q, we_ex_dm_q, we_dm_wb_q;
  logic              ld_id_ex_q;
  logic              byp0_ex_q, byp1_ex_q, byp0_dm_q, byp1_dm_q;

  logic m0_ex, m1_ex, m0_dm, m1_dm, luse;

  assign m0_ex = re0 & we_id_ex_q & (p0_addr == dst_id_ex_q) & (p0_addr != '0);
  assign m1_ex = re1 & we_id_ex_q & (p1_addr == dst_id_ex_q) & (p1_addr != '0);
  assign m0_dm = re0 & we_ex_dm_q & (p0_addr == dst_ex_dm_q) & (p0_addr != '0);
  assign m1_dm = re1 & we_ex_dm_q & (p1_addr == dst_ex_dm_q) & (p1_addr != '0);
  assign luse  = ld_id_ex_q & (m0_ex | m1_ex);

  // Outputs are forced low while reset is asserted, even if ext_stall is high.
  always_comb begin
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_DM  = 1'b0;
    stall_DM_WB  = 1'b0;
    bubble_ID_EX = 1'b0;
    flush_IF_ID  = 1'b0;
    if (rst_n) begin
      if (ext_stall) begin
        stall_IF_ID = 1'b1;
        stall_ID_EX = 1'b1;
        stall_EX_DM = 1'b1;
        stall_DM_WB = 1'b1;
      end else if (flush) begin
        flush_IF_ID  = 1'b1;
        bubble_ID_EX = 1'b1;
      end else if (luse) begin
        stall_IF_ID  = 1'b1;
        bubble_ID_EX = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_id_ex_q <= '0;
      dst_ex_dm_q <= '0;
      dst_dm_wb_q <= '0;
      we_id_ex_q  <= 1'b0;
      we_ex_dm_q  <= 1'b0;
      we_dm_wb_q  <= 1'b0;
      ld_id_ex_q  <= 1'b0;
      byp0_ex_q   <= 1'b0;
      byp1_ex_q   <= 1'b0;
      byp0_dm_q   <= 1'b0;
      byp1_dm_q   <= 1'b0;
    end else if (!ext_stall) begin
      dst_ex_dm_q <= dst_id_ex_q;
      we_ex_dm_q  <= we_id_ex_q;
      dst_dm_wb_q <= dst_ex_dm_q;
      we_dm_wb_q  <= we_ex_dm_q;
      dst_id_ex_q <= dst_addr_ID;
      if (flush || luse) begin
        we_id_ex_q <= 1'b0;
        ld_id_ex_q <= 1'b0;
        byp0_ex_q  <= 1'b0;
        byp1_ex_q  <= 1'b0;
        byp0_dm_q  <= 1'b0;
        byp1_dm_q  <= 1'b0;
      end else begin
        we_id_ex_q <= we_ID;
        ld_id_ex_q <= ld_ID;
        byp0_ex_q  <= m0_ex & ~ld_id_ex_q;
        byp1_ex_q  <= m1_ex & ~ld_id_ex_q;
        byp0_dm_q  <= m0_dm & ~m0_ex;
        byp1_dm_q  <= m1_dm & ~m1_ex;
      end
    end
  end

  assign byp0_EX = byp0_ex_q;
  assign byp1_EX = byp1_ex_q;
  assign byp0_DM = byp0_dm_q;
  assign byp1_DM = byp1_dm_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] luse_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      luse_cnt_q  <= '0;
      flush_cnt_q <= '0;
    end else if (!ext_stall) begin
      if (flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_q <= flush_cnt_q + 1'b1;
      if (!flush && luse && (luse_cnt_q != {CNT_W{1'b1}})) luse_cnt_q <= luse_cnt_q + 1'b1;
    end
  end

  assign luse_cnt  = luse_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign luse_cnt  = '0;
  assign flush_cnt = '0;
`endif

`ifndef SYNTHESIS
  // DM_WB only exists for ordering visibility; RF write-before-read covers that distance.
  a_wb_hold: assert property (@(posedge clk) disable iff (!rst_n)
    ext_stall |=> ($stable(dst_dm_wb_q) && $stable(we_dm_wb_q)));
  a_byp_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(byp0_ex_q && byp0_dm_q) && !(byp1_ex_q && byp1_dm_q));
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboarded directed bench for hazard_ctrl: the driver queues the expected per-cycle outputs,
// a negedge monitor pops and compares them.
module tb_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam bit Perf = 1'b1;
`else
  localparam bit Perf = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  p0_addr = '0, p1_addr = '0, dst_addr_ID = '0;
  logic        re0 = 1'b0, re1 = 1'b0, we_ID = 1'b0, ld_ID = 1'b0;
  logic        flush = 1'b0, ext_stall = 1'b0;
  logic        byp0_EX, byp1_EX, byp0_DM, byp1_DM;
  logic        stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB;
  logic        bubble_ID_EX, flush_IF_ID;
  logic [15:0] luse_cnt, flush_cnt;

  hazard_ctrl #(.ADDR_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
    .dst_addr_ID(dst_addr_ID), .we_ID(we_ID), .ld_ID(ld_ID),
    .flush(flush), .ext_stall(ext_stall),
    .byp0_EX(byp0_EX), .byp1_EX(byp1_EX), .byp0_DM(byp0_DM), .byp1_DM(byp1_DM),
    .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_DM(stall_EX_DM), .stall_DM_WB(stall_DM_WB),
    .bubble_ID_EX(bubble_ID_EX), .flush_IF_ID(flush_IF_ID),
    .luse_cnt(luse_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  byp;    // {byp0_EX, byp1_EX, byp0_DM, byp1_DM}
    logic [3:0]  stall;  // {IF_ID, ID_EX, EX_DM, DM_WB}
    logic        bub;
    logic        fl;
    logic [15:0] lc;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("byp0_EX", {31'd0, byp0_EX}, {31'd0, e.byp[3]});
      chk("byp1_EX", {31'd0, byp1_EX}, {31'd0, e.byp[2]});
      chk("byp0_DM", {31'd0, byp0_DM}, {31'd0, e.byp[1]});
      chk("byp1_DM", {31'd0, byp1_DM}, {31'd0, e.byp[0]});
      chk("stalls", {28'd0, stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB},
          {28'd0, e.stall});
      chk("bubble_ID_EX", {31'd0, bubble_ID_EX}, {31'd0, e.bub});
      chk("flush_IF_ID", {31'd0, flush_IF_ID}, {31'd0, e.fl});
      chk("luse_cnt", {16'd0, luse_cnt}, {16'd0, e.lc});
      chk("flush_cnt", {16'd0, flush_cnt}, {16'd0, e.fc});
    end
  end

  // One pipeline cycle: drive ID-side inputs after the edge and queue what must be seen.
  task automatic step(input bit rst, input logic [3:0] p0, input logic [3:0] p1,
                      input bit r0, input bit r1, input logic [3:0] dst, input bit we,
                      input bit ld, input bit fl, input bit ext,
                      input logic [3:0] ebyp, input logic [3:0] estall, input bit ebub,
                      input bit efl, input int elc, input int efc);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; p0_addr = p0; p1_addr = p1; re0 = r0; re1 = r1;
    dst_addr_ID = dst; we_ID = we; ld_ID = ld; flush = fl; ext_stall = ext;
    e.byp = ebyp; e.stall = estall; e.bub = ebub; e.fl = efl;
    e.lc = Perf ? 16'(elc) : 16'd0;
    e.fc = Perf ? 16'(efc) : 16'd0;
    exp_q.push_back(e);
  endtask

  task automatic nop(input logic [3:0] ebyp, input int elc, input int efc);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ebyp, 4'b0000, 0, 0, elc, efc);
  endtask

  initial begin
    // rst p0 p1 r0 r1 dst we ld fl ext | byp stall bub fl lc fc
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);  // reset over ext_stall
    nop(4'b0000, 0, 0);
    // ADD R3; ADD R5,R3,R4 -> EX bypass
    step(1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    step(1, 3, 4, 1, 1, 5, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    nop(4'b1000, 0, 0);
    // ADD R7; NOP; ADD R8,R7,R1 -> DM bypass
    step(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    nop(4'b0000, 0, 0);
    step(1, 7, 1, 1, 1, 8, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    nop(4'b0010, 0, 0);
    // LW R2; SUB R6,R4,R2 -> one bubble, then DM bypass on src1
    step(1, 1, 0, 1, 0, 2, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    step(1, 4, 2, 1, 1, 6, 1, 0, 0, 0, 4'b0000, 4'b1000, 1, 0, 0, 0);
    step(1, 4, 2, 1, 1, 6, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0);
    nop(4'b0001, 1, 0);
    // R0 destination and re0=0 address match never bypass
    step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0);
    step(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0);
    step(1, 9, 9, 0, 0, 9, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0);
    nop(4'b0000, 1, 0);
    // LW R4 (base R9, DM bypass armed); AND R10,R4,R4 under 3 cycles of ext_stall
    step(1, 9, 0, 1, 0, 4, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++)
      step(1, 4, 4, 1, 1, 10, 1, 0, 0, 1, 4'b0010, 4'b1111, 0, 0, 1, 0);
    step(1, 4, 4, 1, 1, 10, 1, 0, 0, 0, 4'b0010, 4'b1000, 1, 0, 1, 0);
    step(1, 4, 4, 1, 1, 10, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 2, 0);
    nop(4'b0011, 2, 0);
    // LW R5; reader with flush coincident -> flush wins
    step(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 2, 0);
    step(1, 5, 0, 1, 0, 11, 1, 0, 1, 0, 4'b0000, 4'b0000, 1, 1, 2, 0);
    nop(4'b0000, 2, 1);
    // LW R6; reader stalls; reset mid-stall aborts it
    step(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 4'b0000, 4'b0000, 0, 0, 2, 1);
    step(1, 6, 0, 1, 0, 12, 1, 0, 0, 0, 4'b0000, 4'b1000, 1, 0, 2, 1);
    step(0, 6, 0, 1, 0, 12, 1, 0, 0, 1, 4'b0000, 4'b0000, 0, 0, 0, 0);
    step(1, 6, 0, 1, 0, 12, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0);
    nop(4'b0000, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
